// File: rtl/lift_pkg.sv
// Shared definitions for the lift request scheduler: request codes, ring table, FSM states.
// Pure declarations, no logic.
// No flow control here.
package lift_pkg;

    localparam int RING_N = 6;

    localparam logic [2:0] CODE_NONE = 3'b000;
    localparam logic [2:0] CODE_1U   = 3'b001;
    localparam logic [2:0] CODE_2U   = 3'b010;
    localparam logic [2:0] CODE_3U   = 3'b011;
    localparam logic [2:0] CODE_4D   = 3'b100;
    localparam logic [2:0] CODE_3D   = 3'b111;
    localparam logic [2:0] CODE_2D   = 3'b110;

    // Index = ring position; one full up sweep followed by the down sweep.
    localparam logic [RING_N-1:0][2:0] RING_CODE =
        {CODE_2D, CODE_3D, CODE_4D, CODE_3U, CODE_2U, CODE_1U};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_COOL
    } lift_state_e;

    // (pos + step) mod 6, valid for pos, step in 0..5.
    function automatic logic [2:0] ring_add(input logic [2:0] pos, input logic [2:0] step);
        logic [3:0] sum;
        sum = {1'b0, pos} + {1'b0, step};
        if (sum >= 4'd6) begin
            sum = sum - 4'd6;
        end
        return sum[2:0];
    endfunction

endpackage

// File: rtl/lift_req_sched_if.sv
// Call-button / lift-FSM side bundle of the scheduler.
// Wires only, no latency.
// No backpressure; lift_done is the only return strobe.
interface lift_req_sched_if;
    import lift_pkg::*;

    logic [RING_N-1:0] btn;
    logic              lift_done;
    logic [2:0]        din;
    logic              q_empty;
    logic [RING_N-1:0] pending;
    logic              busy;
    logic              err;

    modport master (
        output btn, lift_done,
        input  din, q_empty, pending, busy, err
    );

    modport slave (
        input  btn, lift_done,
        output din, q_empty, pending, busy, err
    );

endinterface

// File: rtl/lift_rr_pick.sv
// Rotating-priority picker: first set pending bit scanning from ptr_i inclusive, wrapping mod 6.
// Combinational, zero latency.
// No flow control; valid_o low when nothing is pending.
module lift_rr_pick
    import lift_pkg::*;
(
    input  logic [RING_N-1:0] pending_i,
    input  logic [2:0]        ptr_i,
    output logic              valid_o,
    output logic [2:0]        idx_o
);

    logic [2:0] scan_pos;

    // Scan farthest-first so the position nearest the pointer is the last writer.
    always_comb begin
        valid_o  = 1'b0;
        idx_o    = '0;
        scan_pos = '0;
        for (int k = RING_N - 1; k >= 0; k--) begin
            scan_pos = ring_add(ptr_i, 3'(k));
            if (pending_i[scan_pos]) begin
                valid_o = 1'b1;
                idx_o   = scan_pos;
            end
        end
    end

endmodule

// File: rtl/lift_req_sched.sv
// Hall-call scheduler: latches button pulses, serves them in up/down ring order; LIFT_SCHED_TIMEOUT_EN adds a WAIT timeout.
// Latency: press in empty IDLE -> din/q_empty valid one edge after the press is latched.
// Backpressure: one request outstanding; holds it until lift_done (or timeout), then one COOL cycle.
module lift_req_sched
    import lift_pkg::*;
#(
    parameter int TIMEOUT_CYC = 200
) (
    input logic             clk,
    input logic             rst_n,
    lift_req_sched_if.slave bus
);

    lift_state_e       state_q, state_d;
    logic [2:0]        ptr_q, ptr_d;
    logic [2:0]        active_q, active_d;
    logic [RING_N-1:0] pending_q, pending_d;
    logic [2:0]        din_q, din_d;
    logic              q_empty_q, q_empty_d;

    logic              pick_vld;
    logic [2:0]        pick_idx;

`ifdef LIFT_SCHED_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
`else
    logic [31:0] timeout_unused;
    assign timeout_unused = 32'(TIMEOUT_CYC);
`endif

    lift_rr_pick u_pick (
        .pending_i (pending_q),
        .ptr_i     (ptr_q),
        .valid_o   (pick_vld),
        .idx_o     (pick_idx)
    );

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        active_d  = active_q;
        din_d     = din_q;
        q_empty_d = q_empty_q;
        // New presses always latch; a completion clear below overrides its own bit.
        pending_d = pending_q | bus.btn;
`ifdef LIFT_SCHED_TIMEOUT_EN
        cnt_d     = cnt_q;
        err_d     = err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (pick_vld) begin
                    din_d     = RING_CODE[pick_idx];
                    q_empty_d = 1'b0;
                    active_d  = pick_idx;
                    state_d   = ST_WAIT;
`ifdef LIFT_SCHED_TIMEOUT_EN
                    cnt_d     = '0;
`endif
                end else begin
                    din_d     = CODE_NONE;
                    q_empty_d = 1'b1;
                end
            end
            ST_WAIT: begin
                if (bus.lift_done) begin
                    pending_d[active_q] = 1'b0;
                    ptr_d     = ring_add(active_q, 3'd1);
                    din_d     = CODE_NONE;
                    q_empty_d = 1'b1;
                    state_d   = ST_COOL;
                end
`ifdef LIFT_SCHED_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                    // Abandon but keep the call latched so it is retried later.
                    err_d     = 1'b1;
                    ptr_d     = ring_add(active_q, 3'd1);
                    din_d     = CODE_NONE;
                    q_empty_d = 1'b1;
                    state_d   = ST_COOL;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            ST_COOL: begin
                din_d     = CODE_NONE;
                q_empty_d = 1'b1;
                state_d   = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            active_q  <= '0;
            pending_q <= '0;
            din_q     <= CODE_NONE;
            q_empty_q <= 1'b1;
`ifdef LIFT_SCHED_TIMEOUT_EN
            cnt_q     <= '0;
            err_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            active_q  <= active_d;
            pending_q <= pending_d;
            din_q     <= din_d;
            q_empty_q <= q_empty_d;
`ifdef LIFT_SCHED_TIMEOUT_EN
            cnt_q     <= cnt_d;
            err_q     <= err_d;
`endif
        end
    end

    assign bus.din     = din_q;
    assign bus.q_empty = q_empty_q;
    assign bus.pending = pending_q;
    assign bus.busy    = (state_q == ST_WAIT);
`ifdef LIFT_SCHED_TIMEOUT_EN
    assign bus.err     = err_q;
`else
    assign bus.err     = 1'b0;
`endif

endmodule

// File: tb/tb_lift_req_sched.sv
// Directed bench for lift_req_sched: ordering, wrap, collisions, async reset, timeout/err.
module tb_lift_req_sched;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    lift_req_sched_if bus();

    lift_req_sched #(.TIMEOUT_CYC(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Inputs change and outputs are sampled on the falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        bus.btn       = '0;
        bus.lift_done = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic press(input logic [5:0] b);
        bus.btn = b;
        step();
        bus.btn = '0;
    endtask

    task automatic done_pulse();
        bus.lift_done = 1'b1;
        step();
        bus.lift_done = 1'b0;
    endtask

    // Advance until a request is presented, at most 8 cycles.
    task automatic wait_req();
        for (int n = 0; n < 8 && bus.q_empty === 1'b1; n++) step();
    endtask

    task automatic test_reset();
        bus.btn = '0; bus.lift_done = 1'b0; rst_n = 1'b0;
        #12;
        checks++; if (bus.din !== 3'b000) begin errors++; $display("FAIL reset_din: got %b want 000", bus.din); end
        checks++; if (bus.q_empty !== 1'b1 || bus.busy !== 1'b0) begin errors++; $display("FAIL reset_flags: q_empty=%b busy=%b want 1 0", bus.q_empty, bus.busy); end
        checks++; if (bus.pending !== 6'b0 || bus.err !== 1'b0) begin errors++; $display("FAIL reset_pend_err: pending=%b err=%b want 000000 0", bus.pending, bus.err); end
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_single();
        do_reset();
        press(6'b000001);
        checks++; if (bus.pending !== 6'b000001 || bus.q_empty !== 1'b1) begin errors++; $display("FAIL single_latch: pending=%b q_empty=%b want 000001 1", bus.pending, bus.q_empty); end
        step();
        checks++; if (bus.din !== 3'b001 || bus.q_empty !== 1'b0 || bus.busy !== 1'b1) begin errors++; $display("FAIL single_issue: din=%b q_empty=%b busy=%b want 001 0 1", bus.din, bus.q_empty, bus.busy); end
        repeat (3) step();
        checks++; if (bus.din !== 3'b001) begin errors++; $display("FAIL single_hold: got %b want 001", bus.din); end
        done_pulse();
        checks++; if (bus.pending !== 6'b0 || bus.din !== 3'b000 || bus.q_empty !== 1'b1 || bus.busy !== 1'b0) begin errors++; $display("FAIL single_done: pending=%b din=%b q_empty=%b busy=%b", bus.pending, bus.din, bus.q_empty, bus.busy); end
        bus.lift_done = 1'b1;
        repeat (2) step();
        bus.lift_done = 1'b0;
        checks++; if (bus.q_empty !== 1'b1 || bus.busy !== 1'b0 || bus.din !== 3'b000) begin errors++; $display("FAIL single_idle: din=%b q_empty=%b busy=%b want 000 1 0", bus.din, bus.q_empty, bus.busy); end
    endtask

    task automatic test_sweep();
        logic [2:0] exp_seq [3];
        exp_seq = '{3'b001, 3'b011, 3'b110};
        do_reset();
        press(6'b100101);
        for (int i = 0; i < 3; i++) begin
            wait_req();
            checks++; if (bus.din !== exp_seq[i] || bus.q_empty !== 1'b0) begin errors++; $display("FAIL sweep_order[%0d]: din=%b q_empty=%b want %b 0", i, bus.din, bus.q_empty, exp_seq[i]); end
            done_pulse();
            checks++; if (bus.q_empty !== 1'b1 || bus.din !== 3'b000) begin errors++; $display("FAIL sweep_gap[%0d]: din=%b q_empty=%b want 000 1", i, bus.din, bus.q_empty); end
        end
        checks++; if (bus.pending !== 6'b0) begin errors++; $display("FAIL sweep_drain: pending=%b want 000000", bus.pending); end
    endtask

    task automatic test_wrap();
        do_reset();
        press(6'b010000);
        wait_req();
        checks++; if (bus.din !== 3'b111) begin errors++; $display("FAIL wrap_first: got %b want 111", bus.din); end
        press(6'b100010);
        checks++; if (bus.din !== 3'b111 || bus.pending !== 6'b110010) begin errors++; $display("FAIL wrap_latch_in_wait: din=%b pending=%b want 111 110010", bus.din, bus.pending); end
        done_pulse();
        wait_req();
        checks++; if (bus.din !== 3'b110) begin errors++; $display("FAIL wrap_2d_first: got %b want 110", bus.din); end
        done_pulse();
        wait_req();
        checks++; if (bus.din !== 3'b010) begin errors++; $display("FAIL wrap_2u_second: got %b want 010", bus.din); end
        done_pulse();
    endtask

    task automatic test_collide();
        do_reset();
        press(6'b000100);
        wait_req();
        checks++; if (bus.din !== 3'b011) begin errors++; $display("FAIL collide_issue: got %b want 011", bus.din); end
        press(6'b001000);
        checks++; if (bus.pending !== 6'b001100 || bus.din !== 3'b011) begin errors++; $display("FAIL collide_press_wait: pending=%b din=%b want 001100 011", bus.pending, bus.din); end
        bus.btn = 6'b000100; bus.lift_done = 1'b1;
        step();
        bus.btn = '0; bus.lift_done = 1'b0;
        checks++; if (bus.pending !== 6'b001000) begin errors++; $display("FAIL collide_clear_wins: pending=%b want 001000", bus.pending); end
        wait_req();
        checks++; if (bus.din !== 3'b100) begin errors++; $display("FAIL collide_next: got %b want 100", bus.din); end
        done_pulse();
    endtask

    task automatic test_async_reset();
        do_reset();
        press(6'b000101);
        wait_req();
        done_pulse();
        wait_req();
        checks++; if (bus.din !== 3'b011 || bus.busy !== 1'b1) begin errors++; $display("FAIL areset_setup: din=%b busy=%b want 011 1", bus.din, bus.busy); end
        press(6'b000001);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (bus.din !== 3'b000 || bus.q_empty !== 1'b1 || bus.pending !== 6'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL areset_immediate: din=%b q_empty=%b pending=%b busy=%b", bus.din, bus.q_empty, bus.pending, bus.busy); end
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_first_pick();
        press(6'b100001);
        wait_req();
        checks++; if (bus.din !== 3'b001) begin errors++; $display("FAIL first_pick_pos0: got %b want 001", bus.din); end
        done_pulse();
        wait_req();
        checks++; if (bus.din !== 3'b110) begin errors++; $display("FAIL first_pick_next: got %b want 110", bus.din); end
        done_pulse();
    endtask

    task automatic test_err();
        do_reset();
`ifdef LIFT_SCHED_TIMEOUT_EN
        press(6'b010100);
        wait_req();
        checks++; if (bus.din !== 3'b011) begin errors++; $display("FAIL to_issue: got %b want 011", bus.din); end
        repeat (7) step();
        checks++; if (bus.busy !== 1'b1 || bus.err !== 1'b0) begin errors++; $display("FAIL to_early: busy=%b err=%b want 1 0", bus.busy, bus.err); end
        step();
        checks++; if (bus.err !== 1'b1 || bus.busy !== 1'b0 || bus.pending !== 6'b010100) begin errors++; $display("FAIL to_fire: err=%b busy=%b pending=%b want 1 0 010100", bus.err, bus.busy, bus.pending); end
        wait_req();
        checks++; if (bus.din !== 3'b111 || bus.err !== 1'b1) begin errors++; $display("FAIL to_next: din=%b err=%b want 111 1", bus.din, bus.err); end
        done_pulse();
`else
        press(6'b000100);
        wait_req();
        repeat (20) step();
        checks++; if (bus.busy !== 1'b1 || bus.err !== 1'b0 || bus.din !== 3'b011) begin errors++; $display("FAIL no_timeout: busy=%b err=%b din=%b want 1 0 011", bus.busy, bus.err, bus.din); end
        done_pulse();
`endif
    endtask

    initial begin
        test_reset();
        test_single();
        test_sweep();
        test_wrap();
        test_collide();
        test_async_reset();
        test_first_pick();
        test_err();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
